// File: rtl/cf_pkg.sv
// rtl/cf_pkg.sv - shared types and constants for the cipher-state byte scheduler
//
// Purpose : state encoding, shift-register operation selects and state-word
//           size shared by cf_byte_sched and anything that drives/observes it.
// Ports   : none (package).
package cf_pkg;

    localparam int NBYTES = 16;

    // Shift-register operation selects (sel_1)
    localparam logic [2:0] SEL_LOAD_C = 3'b000;
    localparam logic [2:0] SEL_LOAD_F = 3'b001;
    localparam logic [2:0] SEL_ROT1B  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/cf_byte_sched.sv
// rtl/cf_byte_sched.sv - load/rotate sequencer and byte collector around the 128-bit state register
//
// Purpose : on an accepted start, loads the external shift register from ReC or
//           ReF, rotates it one byte per cycle for NBYTES cycles while offering
//           each low byte to an external registered look-up table, and assembles
//           the returned bytes into a word held under a valid/ready handshake.
// Ports   :
//   clk       in   system clock (rising edge)
//   rst_n     in   asynchronous active-low reset
//   start     in   single-cycle request, accepted only when idle
//   src_sel   in   0 = load ReC, 1 = load ReF (sampled with accepted start)
//   busy      out  high whenever not idle
//   q_1       in   current shift-register contents
//   EN_R_1    out  shift-register enable
//   sel_1     out  shift-register operation select
//   lut_addr  out  byte presented to the table
//   lut_idx   out  byte position of lut_addr
//   lut_data  in   table result, one cycle after lut_addr/lut_idx
//   out_data  out  assembled result, byte k at [8k+7:8k]
//   out_valid out  result available
//   out_ready in   consumer accepts result
module cf_byte_sched
    import cf_pkg::*;
#(
    parameter int NBYTES_P = NBYTES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  src_sel,
    output logic                  busy,
    input  logic [8*NBYTES_P-1:0] q_1,
    output logic                  EN_R_1,
    output logic [2:0]            sel_1,
    output logic [7:0]            lut_addr,
    output logic [3:0]            lut_idx,
    input  logic [7:0]            lut_data,
    output logic [8*NBYTES_P-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [3:0] LAST_IDX = 4'(NBYTES_P - 1);

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    src_q, src_d;
    // Capture pipeline: position and strobe delayed by one cycle to line up
    // with the registered table output.
    logic [3:0]              idx_q;
    logic                    cap_q;
    logic [8*NBYTES_P-1:0]   out_data_q;
    logic                    accept;

    // Only the low byte of the state register is ever looked at.
    logic unused_q_hi;
    assign unused_q_hi = ^q_1[8*NBYTES_P-1:8];

    assign accept = (state_q == ST_IDLE) && start;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d   = src_sel;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = 4'd0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from the state register only, so the register enable
    // never depends combinationally on start.
    always_comb begin
        EN_R_1    = 1'b0;
        sel_1     = SEL_LOAD_C;
        lut_addr  = 8'h00;
        lut_idx   = 4'h0;
        out_valid = 1'b0;
        unique case (state_q)
            ST_LOAD: begin
                EN_R_1 = 1'b1;
                sel_1  = src_q ? SEL_LOAD_F : SEL_LOAD_C;
            end
            ST_SHIFT: begin
                EN_R_1   = 1'b1;
                sel_1    = SEL_ROT1B;
                lut_addr = q_1[7:0];
                lut_idx  = cnt_q;
            end
            ST_DONE: begin
                out_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign out_data = out_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            src_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 4'd0;
            cap_q <= 1'b0;
        end else begin
            idx_q <= cnt_q;
            cap_q <= (state_q == ST_SHIFT);
        end
    end

    // Clearing on accept guarantees no bytes survive from a previous word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q <= '0;
        end else if (accept) begin
            out_data_q <= '0;
        end else if (cap_q) begin
            out_data_q[{idx_q, 3'b000} +: 8] <= lut_data;
        end
    end

endmodule

// File: doc/cf_byte_sched.md
# cf_byte_sched

Sequencing and collection stage wrapped around the 128-bit shift register that holds the cipher state. On a start pulse it loads the register from ReC or ReF. It then rotates the register one byte per cycle for 16 cycles and presents each low byte to an external registered byte look-up table. The 16 returned bytes are assembled into a 128-bit result, held under a valid/ready handshake for the next round stage.

## Interface
Parameters:
- NBYTES, 16, number of bytes per state word (fixed; other values unsupported)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; accepted only in IDLE
- src_sel  in  1  0 = load ReC, 1 = load ReF; sampled with accepted start
- busy  out  1  high whenever state != IDLE
- q_1  in  128  current shift-register contents
- EN_R_1  out  1  shift-register enable
- sel_1  out  3  shift-register operation select
- lut_addr  out  8  byte to look up (= q_1[7:0] in SHIFT)
- lut_idx  out  4  byte position of lut_addr
- lut_data  in  8  table result, valid one cycle after lut_addr/lut_idx
- out_data  out  128  assembled result, byte k at [8k+7:8k]
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result

## Operation
- FSM states: IDLE, LOAD, SHIFT, DRAIN, DONE.
- IDLE:
  - EN_R_1=0, sel_1=000.
  - start=1 latches src_sel, clears out_data to 0, and moves to LOAD.
- LOAD (1 cycle):
  - EN_R_1=1, sel_1=000 when src_sel=0 (ReC), 001 when src_sel=1 (ReF).
  - Moves to SHIFT with cnt=0.
- SHIFT (16 cycles, cnt 0..15):
  - EN_R_1=1, sel_1=010 (rotate right by 1 byte).
  - lut_addr=q_1[7:0], lut_idx=cnt.
  - cnt increments each cycle; cnt=15 moves to DRAIN.
  - After 16 rotations the register again holds the loaded word.
- Capture pipeline:
  - idx_d<=cnt and cap_d<=(state==SHIFT) are registered every cycle.
  - When cap_d=1, lut_data is written to out_data byte idx_d.
- DRAIN (1 cycle):
  - EN_R_1=0; captures the byte for cnt=15.
  - Moves to DONE.
- DONE:
  - out_valid=1 and EN_R_1=0.
  - out_data and out_valid stay stable until out_ready=1, then the FSM returns to IDLE.
- Port values outside the states listed: lut_addr=0, lut_idx=0, out_valid=0.
- start while busy: ignored, no queuing.
- start in the same cycle as the DONE handshake: ignored, because the state is not yet IDLE.
- Reset, including mid-operation:
  - Returns to IDLE.
  - cnt, idx_d, cap_d, out_data, out_valid, EN_R_1, sel_1, lut_addr and lut_idx all reset to 0.
  - A partial result is discarded.

## Timing
- start sampled at edge T:
  - LOAD in cycle T+1.
  - SHIFT in cycles T+2..T+17.
  - DRAIN in cycle T+18.
  - out_valid first high in cycle T+19.
- Minimum start-to-start period: 20 cycles, with out_ready held high.
- EN_R_1 is high for exactly 17 consecutive cycles per operation.
- EN_R_1 and sel_1 are combinational from the state register; no same-cycle dependency on start.
- out_data bytes update one cycle after the corresponding lut_addr.

## Structure
- Shared package cf_pkg holds:
  - the state enum;
  - SEL_LOAD_C=3'b000, SEL_LOAD_F=3'b001, SEL_ROT1B=3'b010;
  - NBYTES=16.
- Single module; no sub-module needed. The byte-write decoder stays inline.

## Test plan
- Identity LUT (lut_data = previous lut_addr), src_sel=0, ReC=128'h0F0E..0100 -> out_data=128'h0F0E..0100 at T+19; q_1 equals the loaded ReC after the operation.
- XOR LUT (lut_data = addr ^ {4'h0,idx}), src_sel=1, ReF=all 8'hA5 -> byte k = 8'hA5^k; EN_R_1 high exactly 17 cycles.
- out_ready held low 10 cycles after out_valid -> out_valid and out_data stable throughout; IDLE the cycle after out_ready=1.
- start pulsed during SHIFT and in the DONE handshake cycle -> both ignored; exactly one result produced.
- rst_n low at cnt=7 -> all outputs 0 immediately; a new start afterward gives a correct full result.
- Back-to-back operations with out_ready=1 and start re-issued in IDLE -> starts 20 cycles apart; results independent, with no leftover bytes from the previous word.
